carry_select_serial_subtractor: RTL and testbench
=================================================

Name: carry_select_serial_subtractor

Overview:
- Multi-cycle 32-bit subtractor computing diff = a - b - bin, one SLICE-bit slice per clock.
- Each slice uses carry-select: both borrow-in candidates are precomputed and the registered borrow picks one.
- Valid/ready handshake on input and output, so it sits between a stimulus/operand source and a result consumer.
- It is the subtract counterpart to the team's 32-bit modified carry-select adder, and both share the same operand and result widths.

Parameters:
- WIDTH, 32, operand and result width in bits; must be an integer multiple of SLICE.
- SLICE, 8, bits processed per RUN cycle. NSLICE = WIDTH/SLICE, default 4.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands a, b, bin valid
- in_ready  output  1  block can accept operands; high only in IDLE
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow-in (chaining)
- out_valid  output  1  diff, bout, ovf valid; high only in DONE
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
- bout  output  1  borrow-out; 1 iff unsigned a < b + bin
- ovf  output  1  signed overflow: a[MSB] != b[MSB] and diff[MSB] != a[MSB]

Behaviour:
- Reset (async, any state):
  - state=IDLE; slice index=0; borrow=0.
  - Operand regs, diff, bout, ovf all 0; out_valid=0.
  - in_ready=1 while in IDLE, including during reset.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On edge with in_valid=1, capture a, b, bin; set borrow=bin and idx=0; go to RUN.
  - Later changes on a/b/bin are ignored until the next accept.
- RUN, per edge (in_ready=0, out_valid=0):
  - Candidate 0: s0 = a_s + ~b_s + 1. Candidate 1: s1 = a_s + ~b_s. Both are SLICE+1 bits.
  - Select s1 if borrow else s0. Write the low SLICE bits into diff[idx*SLICE +: SLICE].
  - borrow <= ~carry of the selected candidate. idx <= idx+1.
  - On the edge that processes idx=NSLICE-1: bout <= the new borrow; ovf computed from the captured a, b and the final diff MSB; go to DONE.
- Latency: out_valid rises exactly NSLICE edges after the accepting edge (4 by default).
- DONE:
  - out_valid=1. diff, bout, ovf held stable while out_ready=0, for any number of cycles.
  - On edge with out_ready=1, go to IDLE. diff, bout, ovf keep their values; out_valid drops.
- Throughput: one operation per NSLICE+2 cycles minimum. No overlap of accept and complete.
- in_valid in RUN/DONE is ignored; the source must hold it until in_ready.
- diff is partially updated during RUN. Only sample it when out_valid=1.
- Reset asserted mid-RUN or in DONE aborts the operation. There is no output pulse, and after release the block is in IDLE with all outputs 0.
- Width rules:
  - All arithmetic is unsigned modulo 2^WIDTH; bout is the unsigned borrow, ovf the two's-complement overflow.
  - bin=1 with a=b gives diff all-ones and bout=1.

Test Plan:
- Basic: a=32'h00000001, b=32'h00000001, bin=0 -> diff=32'h00000000, bout=0, ovf=0; out_valid exactly 4 cycles after accept.
- Borrow chain across all slices: a=32'h00000001, b=32'h00000002 -> diff=32'hFFFFFFFF, bout=1, ovf=0. Then a=32'hAAAA0004, b=32'hABCD0004 -> diff=32'hFEDD0000, bout=1, ovf=0.
- Signed overflow: a=32'h80000000, b=32'h00000001 -> diff=32'h7FFFFFFF, bout=0, ovf=1. Then a=32'h7FFFFFFF, b=32'hFFFFFFFF -> diff=32'h80000000, bout=1, ovf=1.
- Borrow-in: a=b=32'h12340003, bin=1 -> diff=32'hFFFFFFFF, bout=1. Then a=32'hFFFF0006, b=32'h12560006, bin=1 -> diff=32'hEDA8FFFF, bout=0.
- Handshake: hold out_ready=0 for 6 cycles in DONE -> out_valid, diff, bout, ovf stable. Toggle a/b and pulse in_valid during RUN/DONE -> result unchanged and in_ready=0. out_ready=1 -> IDLE next edge, in_ready=1.
- Reset mid-op: assert rst after 2 RUN edges -> immediately out_valid=0 and diff=0. After release, new op a=32'h00000010, b=32'h00000001 -> diff=32'h0000000F with normal latency.

Source files
------------

// File: rtl/carry_select_serial_subtractor.sv
// ---------------------------------------------------------------------------
// carry_select_serial_subtractor
//
// Multi-cycle subtractor: diff = a - b - bin (modulo 2^WIDTH), processed one
// SLICE-bit slice per clock from LSB to MSB. Each slice computes both
// borrow-in candidates in parallel, and the registered borrow selects one.
// Operands are taken through a valid/ready handshake. The result is then
// offered through a second valid/ready handshake.
//
// Ports
//   clk        in   single clock, all state updates on the rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   a, b and bin are valid
//   in_ready   out  operands can be accepted (high only in IDLE)
//   a          in   [WIDTH] minuend
//   b          in   [WIDTH] subtrahend
//   bin        in   borrow-in, for chaining
//   out_valid  out  diff, bout and ovf are valid (high only in DONE)
//   out_ready  in   the consumer accepts the result
//   diff       out  [WIDTH] a - b - bin, modulo 2^WIDTH
//   bout       out  borrow-out, set iff unsigned a < b + bin
//   ovf        out  two's-complement overflow of the subtraction
// ---------------------------------------------------------------------------
module carry_select_serial_subtractor #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // One slice of a + ~b + cin. The carry-out is the inverted borrow-out.
  function automatic logic [SLICE:0] slice_sub(
    input logic [SLICE-1:0] a_s,
    input logic [SLICE-1:0] b_s,
    input logic             cin
  );
    slice_sub = {1'b0, a_s} + {1'b0, ~b_s} + {{SLICE{1'b0}}, cin};
  endfunction

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IDXW-1:0]  r_idx;
  logic             r_borrow;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [SLICE-1:0] w_a_s;
  logic [SLICE-1:0] w_b_s;
  logic [SLICE:0]   w_s0;
  logic [SLICE:0]   w_s1;
  logic [SLICE:0]   w_sel;
  logic             w_new_borrow;
  logic             w_last;

  // Slice extraction and the two carry-select candidates.
  always_comb begin
    w_a_s        = r_a[r_idx*SLICE +: SLICE];
    w_b_s        = r_b[r_idx*SLICE +: SLICE];
    // s0 assumes no borrow pending (add the +1 of the two's complement).
    // s1 assumes a borrow pending, which cancels that +1.
    w_s0         = slice_sub(w_a_s, w_b_s, 1'b1);
    w_s1         = slice_sub(w_a_s, w_b_s, 1'b0);
    if (r_borrow) begin
      w_sel = w_s1;
    end else begin
      w_sel = w_s0;
    end
    w_new_borrow = ~w_sel[SLICE];
    w_last       = (r_idx == LAST_IDX);
  end

  // Next-state logic for the IDLE/RUN/DONE control FSM.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_next_state = S_RUN;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_RUN;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_DONE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State register with the registered handshake flags derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_in_ready  <= (w_next_state == S_IDLE);
      r_out_valid <= (w_next_state == S_DONE);
    end
  end

  // Operand capture, per-slice datapath and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= {WIDTH{1'b0}};
      r_b      <= {WIDTH{1'b0}};
      r_idx    <= {IDXW{1'b0}};
      r_borrow <= 1'b0;
      r_diff   <= {WIDTH{1'b0}};
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= bin;
            r_idx    <= {IDXW{1'b0}};
          end else begin
            r_idx    <= r_idx;
          end
        end
        S_RUN: begin
          r_diff[r_idx*SLICE +: SLICE] <= w_sel[SLICE-1:0];
          r_borrow                     <= w_new_borrow;
          r_idx                        <= r_idx + IDXW'(1);
          if (w_last) begin
            r_bout <= w_new_borrow;
            // The top bit of the last slice is the final diff MSB.
            r_ovf  <= (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                      (w_sel[SLICE-1] != r_a[WIDTH-1]);
          end else begin
            r_bout <= r_bout;
          end
        end
        S_DONE: begin
          r_idx <= r_idx;
        end
        default: begin
          r_idx <= {IDXW{1'b0}};
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign diff      = r_diff;
  assign bout      = r_bout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_carry_select_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_carry_select_serial_subtractor
//
// Directed self-checking bench for carry_select_serial_subtractor. The
// expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_carry_select_serial_subtractor;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] diff;
  logic        bout;
  logic        ovf;

  int n_checks;
  int n_errors;

  carry_select_serial_subtractor dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one operation and check the result. With disturb set, the inputs
  // are scrambled during RUN/DONE and DONE is held for six cycles.
  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                        input logic tbin, input logic [31:0] ediff, input logic ebout,
                        input logic eovf, input bit disturb);
    int lat;
    @(negedge clk);
    check({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    a = ta; b = tb; bin = tbin; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (disturb && !out_valid) begin
        check({tag, "_run_rdy"}, {31'd0, in_ready}, 32'd0);
        a = $urandom; b = $urandom; bin = ~bin; in_valid = ~in_valid;
      end
    end while (!out_valid && lat < 20);
    check({tag, "_lat"}, 32'(lat), 32'd4);
    check({tag, "_diff"}, diff, ediff);
    check({tag, "_bout"}, {31'd0, bout}, {31'd0, ebout});
    check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eovf});
    if (disturb) begin
      for (int i = 0; i < 6; i++) begin
        a = $urandom; b = $urandom; in_valid = ~in_valid;
        @(negedge clk);
        check({tag, "_hold_v"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_hold_rdy"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_hold_d"}, diff, ediff);
        check({tag, "_hold_bo"}, {31'd0, bout}, {31'd0, ebout});
        check({tag, "_hold_ov"}, {31'd0, ovf}, {31'd0, eovf});
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_ov_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_idle_rdy"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_keep_d"}, diff, ediff);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = 32'd0; b = 32'd0; bin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rdy", {31'd0, in_ready}, 32'd1);
    check("rst_ov", {31'd0, out_valid}, 32'd0);
    check("rst_diff", diff, 32'd0);
    check("rst_bo", {31'd0, bout}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    rst = 1'b0;

    run_op("basic", 32'h00000001, 32'h00000001, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0);
    run_op("chain1", 32'h00000001, 32'h00000002, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    run_op("chain2", 32'hAAAA0004, 32'hABCD0004, 1'b0, 32'hFEDD0000, 1'b1, 1'b0, 1'b0);
    run_op("ovf1", 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);
    run_op("ovf2", 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1, 1'b0);
    run_op("bin1", 32'h12340003, 32'h12340003, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    run_op("bin2", 32'hFFFF0006, 32'h12560006, 1'b1, 32'hEDA8FFFF, 1'b0, 1'b0, 1'b0);
    run_op("hshk", 32'h00001000, 32'h00000001, 1'b0, 32'h00000FFF, 1'b0, 1'b0, 1'b1);

    // Reset after two RUN edges: 0 - 1 has already written 0x0000FFFF.
    @(negedge clk);
    a = 32'h00000000; b = 32'h00000001; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mrst_ov", {31'd0, out_valid}, 32'd0);
    check("mrst_diff", diff, 32'd0);
    check("mrst_rdy", {31'd0, in_ready}, 32'd1);
    check("mrst_bo", {31'd0, bout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst", 32'h00000010, 32'h00000001, 1'b0, 32'h0000000F, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
